// File: rtl/line_cmd_arbiter_if.sv
// line_cmd_arbiter_if
//   Bundles every handshake and bus signal around the line-draw arbiter:
//   requester command channel, engine launch/pixel channel, framebuffer
//   write port and status.
//   slave  modport : the arbiter itself
//   master modport : the environment (drawing clients, engine, framebuffer)
//   Parameters: NREQ requesters, COLOR_W colour bits.
interface line_cmd_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int COLOR_W = 8
);
    localparam int GW = $clog2(NREQ);

    // requester side
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*44-1:0]      req_coord;   // per requester {x0,y0,x1,y1}
    logic [NREQ*COLOR_W-1:0] req_color;
    logic [NREQ-1:0]         req_done;

    // engine side
    logic                    eng_start;
    logic [10:0]             eng_x0;
    logic [10:0]             eng_y0;
    logic [10:0]             eng_x1;
    logic [10:0]             eng_y1;
    logic                    eng_plot;
    logic [10:0]             eng_x;
    logic [10:0]             eng_y;
    logic                    eng_done;

    // framebuffer write port
    logic                    fb_we;
    logic [10:0]             fb_x;
    logic [10:0]             fb_y;
    logic [COLOR_W-1:0]      fb_color;

    // status
    logic                    busy;
    logic [GW-1:0]           grant_id;
    logic [21:0]             pix_count;

    modport slave (
        input  req_valid, req_coord, req_color,
        input  eng_plot, eng_x, eng_y, eng_done,
        output req_ready, req_done,
        output eng_start, eng_x0, eng_y0, eng_x1, eng_y1,
        output fb_we, fb_x, fb_y, fb_color,
        output busy, grant_id, pix_count
    );

    modport master (
        output req_valid, req_coord, req_color,
        output eng_plot, eng_x, eng_y, eng_done,
        input  req_ready, req_done,
        input  eng_start, eng_x0, eng_y0, eng_x1, eng_y1,
        input  fb_we, fb_x, fb_y, fb_color,
        input  busy, grant_id, pix_count
    );
endinterface

// File: rtl/line_cmd_arbiter.sv
// line_cmd_arbiter
//   Shares one line-draw engine between NREQ drawing clients. Commands are
//   taken over per-requester valid/ready, arbitrated round-robin, launched
//   on the engine, and the engine's pixels are forwarded (one registered
//   stage) to the framebuffer tagged with the command colour.
//
//   Ports:
//     clk      : clock
//     rst      : synchronous active-high reset (shared with the engine)
//     bus      : line_cmd_arbiter_if.slave
//                req_valid/req_ready/req_coord/req_color/req_done
//                eng_start/eng_x0..eng_y1/eng_plot/eng_x/eng_y/eng_done
//                fb_we/fb_x/fb_y/fb_color, busy/grant_id/pix_count
//
//   Optional build macro: LINE_ARB_CLIP_EN
//     defined   : pixels with eng_x >= SCREEN_W or eng_y >= SCREEN_H are
//                 dropped (no fb_we, not counted); the line still completes.
//     undefined : every engine pixel is forwarded; SCREEN_W/H unused.
module line_cmd_arbiter #(
    parameter int NREQ     = 4,
    parameter int COLOR_W  = 8,
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600
) (
    input  logic               clk,
    input  logic               rst,
    line_cmd_arbiter_if.slave  bus
);
    localparam int GW    = $clog2(NREQ);
    localparam int CMD_W = 44;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_DRAW   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [GW-1:0]        r_rr_ptr;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        w_grant;
    logic                 w_found;
    logic                 w_accept;
    logic [NREQ-1:0]      w_ready;
    logic                 w_eng_start;
    logic                 w_busy;

    logic [CMD_W-1:0]     w_cmd;
    logic [COLOR_W-1:0]   w_color;
    logic                 w_keep;

    logic [10:0]          r_x0;
    logic [10:0]          r_y0;
    logic [10:0]          r_x1;
    logic [10:0]          r_y1;
    logic [COLOR_W-1:0]   r_color;

    logic                 r_fb_we;
    logic [10:0]          r_fb_x;
    logic [10:0]          r_fb_y;
    logic [COLOR_W-1:0]   r_fb_color;
    logic [21:0]          r_pix_count;
    logic [NREQ-1:0]      r_done;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or after r_rr_ptr.
    // Walking k downwards and overwriting leaves the smallest k (closest
    // to the pointer) as the winner.
    // ------------------------------------------------------------------
    always_comb begin : rr_search
        logic [GW-1:0] v_idx;
        w_found = 1'b0;
        w_grant = '0;
        v_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = GW'((int'(r_rr_ptr) + k) % NREQ);
            if (bus.req_valid[v_idx]) begin
                w_found = 1'b1;
                w_grant = v_idx;
            end
        end
    end

    // Selected command and colour of the current winner.
    assign w_cmd   = bus.req_coord[int'(w_grant)*CMD_W +: CMD_W];
    assign w_color = bus.req_color[int'(w_grant)*COLOR_W +: COLOR_W];

    // ------------------------------------------------------------------
    // Pixel filter. Unsigned compare so wrapped negatives are clipped.
    // ------------------------------------------------------------------
`ifdef LINE_ARB_CLIP_EN
    assign w_keep = bus.eng_plot &&
                    (32'(bus.eng_x) < SCREEN_W) &&
                    (32'(bus.eng_y) < SCREEN_H);
`else
    logic w_unused_screen;
    assign w_unused_screen = (SCREEN_W > 0) ^ (SCREEN_H > 0);
    assign w_keep = bus.eng_plot;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_accept    = 1'b0;
        w_eng_start = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_found) begin
                    // ready only goes to the winner, so valid&ready is
                    // simply "someone is valid" here.
                    w_ready[w_grant] = 1'b1;
                    w_accept         = 1'b1;
                    w_state_nxt      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_eng_start = 1'b1;
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                if (bus.eng_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_color  <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= GW'((int'(w_grant) + 1) % NREQ);
            r_grant  <= w_grant;
            r_x0     <= w_cmd[43:33];
            r_y0     <= w_cmd[32:22];
            r_x1     <= w_cmd[21:11];
            r_y1     <= w_cmd[10:0];
            r_color  <= w_color;
        end
    end

    // ------------------------------------------------------------------
    // Pixel forwarding, pixel count and completion pulse.
    // Engine strobes outside DRAW are ignored entirely.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fb_we     <= 1'b0;
            r_fb_x      <= '0;
            r_fb_y      <= '0;
            r_fb_color  <= '0;
            r_pix_count <= '0;
            r_done      <= '0;
        end else begin
            r_fb_we <= 1'b0;
            r_done  <= '0;
            if (w_accept) begin
                r_pix_count <= '0;
            end
            if (r_state == S_DRAW) begin
                r_fb_we    <= w_keep;
                r_fb_x     <= bus.eng_x;
                r_fb_y     <= bus.eng_y;
                r_fb_color <= r_color;
                // counted here rather than from r_fb_we so a pixel that
                // coincides with eng_done is still in the final count
                if (w_keep) begin
                    r_pix_count <= r_pix_count + 22'd1;
                end
                if (bus.eng_done) begin
                    r_done[r_grant] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = w_ready;
    assign bus.req_done  = r_done;
    assign bus.eng_start = w_eng_start;
    assign bus.eng_x0    = r_x0;
    assign bus.eng_y0    = r_y0;
    assign bus.eng_x1    = r_x1;
    assign bus.eng_y1    = r_y1;
    assign bus.fb_we     = r_fb_we;
    assign bus.fb_x      = r_fb_x;
    assign bus.fb_y      = r_fb_y;
    assign bus.fb_color  = r_fb_color;
    assign bus.busy      = w_busy;
    assign bus.grant_id  = r_grant;
    assign bus.pix_count = r_pix_count;

endmodule
